mem_access_ctrl: RTL and testbench



---
 rtl/mem_access_ctrl_if.sv | 21 ++
 rtl/mem_access_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_if.sv
// Memory bus bundle between the load/store access controller and the memory.
// The controller takes the master side. The memory or bus model takes the slave side.
interface mem_access_ctrl_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Load/store access controller. It turns byte, half and word accesses at any offset
// into one or two word-aligned bus beats, and sign- or zero-extends the load result.
module mem_access_ctrl (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic               is_store_i,
  input  logic               sign_extend_i,
  input  logic [1:0]         datatype_i,
  input  logic [31:0]        addr_i,
  input  logic [31:0]        wdata_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [31:0]        rdata_o,
  output logic               split_o,
  mem_access_ctrl_if.master  bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, BEAT1 = 2'd1, BEAT2 = 2'd2, DONE = 2'd3} state_e;

  state_e      state_q, state_d;
  logic        busy_q, busy_d, done_q, done_d, split_q, split_d;
  logic [31:0] rdata_q, rdata_d;
  logic        is_store_q, is_store_d, sext_q, sext_d;
  logic [1:0]  dtype_q, dtype_d, off_q, off_d;
  logic [3:0]  be_hi_q, be_hi_d;
  logic [31:0] wdata_hi_q, wdata_hi_d, w0_q, w0_d;
  logic        req_q, req_d, we_q, we_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;

  logic [3:0]  size_mask_s;
  logic [7:0]  lane_s;
  logic [63:0] wshift_s;

  function automatic logic [31:0] extend_load(input logic [63:0] pair, input logic [1:0] off,
                                              input logic [1:0] dt, input logic sext);
    logic [63:0] s;
    s = pair >> {off, 3'b000};
    case (dt)
      2'b00:   extend_load = sext ? {{24{s[7]}}, s[7:0]} : {24'h000000, s[7:0]};
      2'b01:   extend_load = sext ? {{16{s[15]}}, s[15:0]} : {16'h0000, s[15:0]};
      default: extend_load = s[31:0];
    endcase
  endfunction

  // Lane mask and lane-aligned store data for the request being presented.
  always_comb begin
    case (datatype_i)
      2'b00:   size_mask_s = 4'b0001;
      2'b01:   size_mask_s = 4'b0011;
      default: size_mask_s = 4'b1111;
    endcase
    lane_s   = {4'b0000, size_mask_s} << addr_i[1:0];
    wshift_s = {32'h00000000, wdata_i} << {addr_i[1:0], 3'b000};
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    split_d    = split_q;
    rdata_d    = rdata_q;
    is_store_d = is_store_q;
    sext_d     = sext_q;
    dtype_d    = dtype_q;
    off_d      = off_q;
    be_hi_d    = be_hi_q;
    wdata_hi_d = wdata_hi_q;
    w0_d       = w0_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d    = BEAT1;
          is_store_d = is_store_i;
          sext_d     = sign_extend_i;
          dtype_d    = datatype_i;
          off_d      = addr_i[1:0];
          be_hi_d    = lane_s[7:4];
          wdata_hi_d = wshift_s[63:32];
          split_d    = |lane_s[7:4];
          req_d      = 1'b1;
          we_d       = is_store_i;
          addr_d     = {addr_i[31:2], 2'b00};
          be_d       = lane_s[3:0];
          wdata_d    = wshift_s[31:0];
        end else begin
          state_d = IDLE;
        end
      end
      BEAT1: begin
        if (bus.mem_ready) begin
          w0_d = bus.mem_rdata;
          if (split_q) begin
            state_d = BEAT2;
            addr_d  = addr_q + 32'd4;
            be_d    = be_hi_q;
            wdata_d = wdata_hi_q;
          end else begin
            state_d = DONE;
            req_d   = 1'b0;
            we_d    = 1'b0;
            addr_d  = 32'h00000000;
            be_d    = 4'b0000;
            wdata_d = 32'h00000000;
            if (!is_store_q) begin
              rdata_d = extend_load({32'h00000000, bus.mem_rdata}, off_q, dtype_q, sext_q);
            end else begin
              rdata_d = rdata_q;
            end
          end
        end else begin
          state_d = BEAT1;
        end
      end
      BEAT2: begin
        if (bus.mem_ready) begin
          state_d = DONE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          addr_d  = 32'h00000000;
          be_d    = 4'b0000;
          wdata_d = 32'h00000000;
          if (!is_store_q) begin
            rdata_d = extend_load({bus.mem_rdata, w0_q}, off_q, dtype_q, sext_q);
          end else begin
            rdata_d = rdata_q;
          end
        end else begin
          state_d = BEAT2;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      split_q    <= 1'b0;
      rdata_q    <= 32'h00000000;
      is_store_q <= 1'b0;
      sext_q     <= 1'b0;
      dtype_q    <= 2'b00;
      off_q      <= 2'b00;
      be_hi_q    <= 4'b0000;
      wdata_hi_q <= 32'h00000000;
      w0_q       <= 32'h00000000;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= 32'h00000000;
      be_q       <= 4'b0000;
      wdata_q    <= 32'h00000000;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      split_q    <= split_d;
      rdata_q    <= rdata_d;
      is_store_q <= is_store_d;
      sext_q     <= sext_d;
      dtype_q    <= dtype_d;
      off_q      <= off_d;
      be_hi_q    <= be_hi_d;
      wdata_hi_q <= wdata_hi_d;
      w0_q       <= w0_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign split_o       = split_q;
  assign rdata_o       = rdata_q;
  assign bus.mem_req   = req_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_be    = be_q;
  assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl. Inputs are driven and outputs are sampled on the
// falling clock edge, against hand-computed expected values.
module tb_mem_access_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0, is_store_i = 1'b0, sign_extend_i = 1'b0;
  logic [1:0]  datatype_i = 2'b00;
  logic [31:0] addr_i = 32'h0, wdata_i = 32'h0;
  logic        busy_o, done_o, split_o;
  logic [31:0] rdata_o;
  int          checks = 0;
  int          failures = 0;

  mem_access_ctrl_if bus_if ();

  mem_access_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .is_store_i(is_store_i),
    .sign_extend_i(sign_extend_i), .datatype_i(datatype_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .busy_o(busy_o), .done_o(done_o), .rdata_o(rdata_o),
    .split_o(split_o), .bus(bus_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_bus(input string tag, input logic req, input logic we,
                         input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wd);
    chk({tag, ".req"},   {31'h0, bus_if.mem_req}, {31'h0, req});
    chk({tag, ".we"},    {31'h0, bus_if.mem_we},  {31'h0, we});
    chk({tag, ".addr"},  bus_if.mem_addr,          addr);
    chk({tag, ".be"},    {28'h0, bus_if.mem_be},  {28'h0, be});
    chk({tag, ".wdata"}, bus_if.mem_wdata,         wd);
  endtask

  task automatic chk_stat(input string tag, input logic busy, input logic done, input logic split);
    chk({tag, ".busy"},  {31'h0, busy_o},  {31'h0, busy});
    chk({tag, ".done"},  {31'h0, done_o},  {31'h0, done});
    chk({tag, ".split"}, {31'h0, split_o}, {31'h0, split});
  endtask

  // Present a request for one cycle, then scramble the inputs, which are don't-care after capture.
  task automatic issue(input logic st, input logic sx, input logic [1:0] dt,
                       input logic [31:0] a, input logic [31:0] wd);
    start_i = 1'b1; is_store_i = st; sign_extend_i = sx; datatype_i = dt;
    addr_i = a; wdata_i = wd;
    @(negedge clk);
    start_i = 1'b0; is_store_i = ~st; sign_extend_i = ~sx; datatype_i = ~dt;
    addr_i = 32'h5A5A5A5A; wdata_i = 32'h13579BDF;
  endtask

  initial begin
    bus_if.mem_ready = 1'b1;
    bus_if.mem_rdata = 32'h0;

    // Reset state
    @(negedge clk);
    chk_stat("rst", 1'b0, 1'b0, 1'b0);
    chk_bus("rst", 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    chk("rst.rdata", rdata_o, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Aligned LW: done two cycles after start
    bus_if.mem_rdata = 32'hDEADBEEF;
    issue(1'b0, 1'b0, 2'b10, 32'h00000100, 32'h0);
    chk_stat("lw.b1", 1'b1, 1'b0, 1'b0);
    chk_bus("lw.b1", 1'b1, 1'b0, 32'h00000100, 4'hF, 32'h0);
    @(negedge clk);
    chk_stat("lw.done", 1'b1, 1'b1, 1'b0);
    chk("lw.rdata", rdata_o, 32'hDEADBEEF);
    chk_bus("lw.done", 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    @(negedge clk);
    chk_stat("lw.idle", 1'b0, 1'b0, 1'b0);
    chk("lw.hold", rdata_o, 32'hDEADBEEF);

    // LB sign-extended at offset 3
    bus_if.mem_rdata = 32'h80FFFFFF;
    issue(1'b0, 1'b1, 2'b00, 32'h00000103, 32'h0);
    chk_bus("lb.b1", 1'b1, 1'b0, 32'h00000100, 4'h8, 32'h0);
    @(negedge clk);
    chk_stat("lb.done", 1'b1, 1'b1, 1'b0);
    chk("lb.rdata", rdata_o, 32'hFFFFFF80);
    @(negedge clk);

    // LBU at offset 3
    issue(1'b0, 1'b0, 2'b00, 32'h00000103, 32'h0);
    chk_bus("lbu.b1", 1'b1, 1'b0, 32'h00000100, 4'h8, 32'h0);
    @(negedge clk);
    chk("lbu.rdata", rdata_o, 32'h00000080);
    @(negedge clk);

    // Split SW at offset 2: done three cycles after start, rdata untouched
    issue(1'b1, 1'b0, 2'b10, 32'h00000102, 32'hAABBCCDD);
    chk_stat("sw.b1", 1'b1, 1'b0, 1'b1);
    chk_bus("sw.b1", 1'b1, 1'b1, 32'h00000100, 4'hC, 32'hCCDD0000);
    @(negedge clk);
    chk_stat("sw.b2", 1'b1, 1'b0, 1'b1);
    chk_bus("sw.b2", 1'b1, 1'b1, 32'h00000104, 4'h3, 32'h0000AABB);
    @(negedge clk);
    chk_stat("sw.done", 1'b1, 1'b1, 1'b1);
    chk("sw.rdata", rdata_o, 32'h00000080);
    @(negedge clk);
    chk_stat("sw.idle", 1'b0, 1'b0, 1'b1);

    // LH across the top of the address space wraps to address 0
    bus_if.mem_rdata = 32'h12000000;
    issue(1'b0, 1'b0, 2'b01, 32'hFFFFFFFF, 32'h0);
    chk_bus("lh.b1", 1'b1, 1'b0, 32'hFFFFFFFC, 4'h8, 32'h0);
    @(negedge clk);
    bus_if.mem_rdata = 32'h00000034;
    chk_bus("lh.b2", 1'b1, 1'b0, 32'h00000000, 4'h1, 32'h0);
    @(negedge clk);
    chk_stat("lh.done", 1'b1, 1'b1, 1'b1);
    chk("lh.rdata", rdata_o, 32'h00003412);
    @(negedge clk);

    // LW with three wait cycles; a start pulse while busy is ignored
    bus_if.mem_ready = 1'b0;
    bus_if.mem_rdata = 32'hCAFEF00D;
    issue(1'b0, 1'b0, 2'b10, 32'h00000200, 32'h0);
    chk_bus("wait.c1", 1'b1, 1'b0, 32'h00000200, 4'hF, 32'h0);
    start_i = 1'b1; is_store_i = 1'b1; addr_i = 32'h00000301; datatype_i = 2'b00;
    @(negedge clk);
    start_i = 1'b0;
    chk_bus("wait.c2", 1'b1, 1'b0, 32'h00000200, 4'hF, 32'h0);
    chk_stat("wait.c2", 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk_bus("wait.c3", 1'b1, 1'b0, 32'h00000200, 4'hF, 32'h0);
    @(negedge clk);
    bus_if.mem_ready = 1'b1;
    chk_bus("wait.c4", 1'b1, 1'b0, 32'h00000200, 4'hF, 32'h0);
    chk_stat("wait.c4", 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk_stat("wait.done", 1'b1, 1'b1, 1'b0);
    chk("wait.rdata", rdata_o, 32'hCAFEF00D);
    @(negedge clk);
    chk_stat("wait.idle", 1'b0, 1'b0, 1'b0);
    chk_bus("wait.idle", 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);

    // Reset during BEAT2 of a split store aborts the access
    issue(1'b1, 1'b0, 2'b10, 32'h00000102, 32'hAABBCCDD);
    @(negedge clk);
    chk_bus("abort.b2", 1'b1, 1'b1, 32'h00000104, 4'h3, 32'h0000AABB);
    #1 rst_n = 1'b0;
    #1;
    chk_stat("abort.rst", 1'b0, 1'b0, 1'b0);
    chk_bus("abort.rst", 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    chk("abort.rdata", rdata_o, 32'h0);
    @(negedge clk);
    chk_stat("abort.hold", 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk_stat("abort.after", 1'b0, 1'b0, 1'b0);

    // Aligned SB after reset completes normally
    issue(1'b1, 1'b0, 2'b00, 32'h00000101, 32'h000000EE);
    chk_bus("sb.b1", 1'b1, 1'b1, 32'h00000100, 4'h2, 32'h0000EE00);
    chk_stat("sb.b1", 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk_stat("sb.done", 1'b1, 1'b1, 1'b0);
    chk("sb.rdata", rdata_o, 32'h0);
    @(negedge clk);
    chk_stat("sb.idle", 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
